// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PRESCALE_W_DEF = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-window edge counter with 3-point majority sampling of the synchronized line.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_s,
  input  logic                  idle,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]            smp_q, smp_d;
  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] mid_edge;

  always_comb begin
    last_edge  = prescale - PRESCALE_W'(1);
    mid_edge   = prescale >> 1;
    edge_cnt_d = edge_cnt_q;
    smp_d      = smp_q;
    // The start-detect cycle is edge 0, so the first START cycle is already edge 1.
    if (idle) begin
      edge_cnt_d = rx_s ? '0 : PRESCALE_W'(1);
    end else if (edge_cnt_q >= last_edge) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
    if (!idle) begin
      if (edge_cnt_q == mid_edge - PRESCALE_W'(1)) smp_d[0] = rx_s;
      if (edge_cnt_q == mid_edge)                  smp_d[1] = rx_s;
      if (edge_cnt_q == mid_edge + PRESCALE_W'(1)) smp_d[2] = rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      smp_q      <= '1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

  assign sampled_bit = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  // >= keeps the window bounded even if Prescale shrinks mid-frame.
  assign bit_done    = !idle && (edge_cnt_q >= last_edge);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: line synchronizer, frame FSM, data/parity/stop checks and output registers.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int unsigned    BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic [1:0]            sync_q, sync_d;
  rx_state_e             state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  rx_s;
  logic                  exp_par;
  logic                  sampled_bit;
  logic                  bit_done;

  assign rx_s = sync_q[1];

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .rx_s        (rx_s),
    .idle        (state_q == IDLE),
    .prescale    (Prescale),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done)
  );

  always_comb begin
    sync_d       = {sync_q[0], RX_IN};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    exp_par      = (^shift_q) ^ (PAR_TYP == PAR_ODD);
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (bit_done) begin
          if (sampled_bit) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d[bit_cnt_q] = sampled_bit;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_err_d = (sampled_bit != exp_par);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          stp_err_d = !sampled_bit;
          state_d   = IDLE;
          if (sampled_bit && !par_err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q       <= '1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = data_valid_q;
  assign Par_Err    = par_err_q;
  assign Stp_Err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_pdata;
  logic       exp_par;
  logic       exp_stp;
  logic [7:0] g, e;

  uart_rx_fsm #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  always #5 CLK = ~CLK;

  // Every cycle with Data_Valid high is one delivered byte; a stretched pulse shows up as a duplicate.
  always @(negedge CLK) if (Data_Valid === 1'b1) got_q.push_back(P_DATA);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b, input bit noisy);
    int ps   = int'(Prescale);
    int flip = noisy ? (ps / 2 - 1 + int'($urandom_range(0, 2))) : -1;
    for (int i = 0; i < ps; i++) begin
      RX_IN = (i == flip) ? ~b : b;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input bit noisy);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], noisy);
    if (PAR_EN) send_bit(pbit, 1'b0);
    send_bit(sbit, 1'b0);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PAR_TYP;
  endfunction

  // Frame-level outcome: what a receiver must report for one complete frame.
  function automatic void model_frame(input logic [7:0] d, input logic pbit, input logic sbit);
    logic perr;
    perr    = PAR_EN && (pbit != good_par(d));
    exp_par = perr;
    exp_stp = !sbit;
    if (!perr && sbit) begin
      exp_q.push_back(d);
      exp_pdata = d;
    end
  endfunction

  task automatic test_reset();
    RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) tick();
    checks++;
    if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'd0) begin
      failures++;
      $display("FAIL reset_values: P_DATA=%h DV=%b Par=%b Stp=%b required all 0", P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
    RST = 1'b1;
    exp_pdata = 8'h00; exp_par = 1'b0; exp_stp = 1'b0;
    idle(4);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL reset_no_valid: %0d pulses after reset, required 0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_basic();
    Prescale = 6'd8; PAR_EN = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    model_frame(8'hA5, 1'b0, 1'b1);
    idle(6);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_count: %0d pulses, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL basic_data: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if ({P_DATA, Par_Err, Stp_Err} !== {exp_pdata, exp_par, exp_stp}) begin
      failures++;
      $display("FAIL basic_regs: P_DATA=%h Par=%b Stp=%b required %h %b %b", P_DATA, Par_Err, Stp_Err, exp_pdata, exp_par, exp_stp);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d = 8'h37;
    logic       pb;
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    idle(4);
    for (int k = 0; k < 2; k++) begin
      pb = (k == 0) ? 1'b1 : 1'b0;
      send_frame(d, pb, 1'b1, 1'b0);
      model_frame(d, pb, 1'b1);
      idle(6);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL parity_count[%0d]: %0d pulses, required %0d", k, got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL parity_data[%0d]: got %h required %h", k, g, e); end
      end
      got_q.delete(); exp_q.delete();
      checks++;
      if ({P_DATA, Par_Err, Stp_Err} !== {exp_pdata, exp_par, exp_stp}) begin
        failures++;
        $display("FAIL parity_regs[%0d]: P_DATA=%h Par=%b Stp=%b required %h %b %b", k, P_DATA, Par_Err, Stp_Err, exp_pdata, exp_par, exp_stp);
      end
    end
  endtask

  task automatic test_stop_err();
    logic [7:0] d;
    logic       sb;
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    idle(4);
    for (int k = 0; k < 2; k++) begin
      d  = (k == 0) ? 8'hFF : 8'h00;
      sb = (k == 0) ? 1'b0 : 1'b1;
      send_frame(d, 1'b1, sb, 1'b0);
      model_frame(d, 1'b1, sb);
      idle(6);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL stop_count[%0d]: %0d pulses, required %0d", k, got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL stop_data[%0d]: got %h required %h", k, g, e); end
      end
      got_q.delete(); exp_q.delete();
      checks++;
      if ({P_DATA, Par_Err, Stp_Err} !== {exp_pdata, exp_par, exp_stp}) begin
        failures++;
        $display("FAIL stop_regs[%0d]: P_DATA=%h Par=%b Stp=%b required %h %b %b", k, P_DATA, Par_Err, Stp_Err, exp_pdata, exp_par, exp_stp);
      end
    end
  endtask

  task automatic test_glitch();
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    idle(4);
    RX_IN = 1'b0;
    repeat (3) tick();
    idle(16);
    checks++;
    if (got_q.size() != 0 || {P_DATA, Par_Err, Stp_Err} !== {exp_pdata, exp_par, exp_stp}) begin
      failures++;
      $display("FAIL glitch_ignored: pulses=%0d P_DATA=%h Par=%b Stp=%b required 0 %h %b %b", got_q.size(), P_DATA, Par_Err, Stp_Err, exp_pdata, exp_par, exp_stp);
    end
    got_q.delete();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    model_frame(8'h5A, 1'b0, 1'b1);
    idle(6);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL glitch_count: %0d pulses, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL glitch_data: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] frames[3] = '{8'h01, 8'h80, 8'hC3};
    Prescale = 6'd8; PAR_EN = 1'b0;
    idle(4);
    foreach (frames[i]) begin
      send_frame(frames[i], 1'b0, 1'b1, 1'b1);
      model_frame(frames[i], 1'b0, 1'b1);
    end
    idle(6);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: %0d pulses, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL b2b_data: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if ({P_DATA, Par_Err, Stp_Err} !== {exp_pdata, exp_par, exp_stp}) begin
      failures++;
      $display("FAIL b2b_regs: P_DATA=%h Par=%b Stp=%b required %h %b %b", P_DATA, Par_Err, Stp_Err, exp_pdata, exp_par, exp_stp);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'h99;
    Prescale = 6'd8; PAR_EN = 1'b0;
    idle(4);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    RST = 1'b0;
    #1;
    checks++;
    if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'd0) begin
      failures++;
      $display("FAIL midreset_values: P_DATA=%h DV=%b Par=%b Stp=%b required all 0", P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
    exp_pdata = 8'h00; exp_par = 1'b0; exp_stp = 1'b0;
    idle(3);
    RST = 1'b1;
    idle(4);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_no_valid: %0d pulses, required 0", got_q.size());
    end
    got_q.delete();
    send_frame(8'h42, 1'b0, 1'b1, 1'b0);
    model_frame(8'h42, 1'b0, 1'b1);
    idle(6);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midreset_count: %0d pulses, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL midreset_data: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       pb, sb;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0:       Prescale = 6'd8;
        1:       Prescale = 6'd16;
        default: Prescale = 6'd32;
      endcase
      PAR_EN  = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      idle(2 + int'($urandom_range(0, 4)));
      d  = 8'($urandom_range(0, 255));
      pb = good_par(d) ^ ($urandom_range(0, 4) == 0);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, sb, ($urandom_range(0, 1) == 1));
      model_frame(d, pb, sb);
      idle(6);
      checks++;
      if ({P_DATA, Par_Err, Stp_Err} !== {exp_pdata, exp_par, exp_stp}) begin
        failures++;
        $display("FAIL random_regs[%0d]: P_DATA=%h Par=%b Stp=%b required %h %b %b", n, P_DATA, Par_Err, Stp_Err, exp_pdata, exp_par, exp_stp);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count: %0d pulses, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL random_data: got %h required %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
UART receiver, the counterpart of the UART_TX serializer/output mux. It oversamples the asynchronous serial line RX_IN and detects the start bit. It majority-samples DATA_WIDTH data bits (LSB first), the optional parity bit and the stop bit, then presents the parallel byte with a one-cycle valid pulse. It sits in the UART RX clock domain and feeds the RX data synchronizer toward the system domain.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of the Prescale input (oversampling ratios 8, 16, 32)

Ports:
CLK  input  1  receiver clock (Prescale x baud rate)
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line; idle high; asynchronous to CLK
Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; static while a frame is in progress
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_DATA  output  DATA_WIDTH  last good received byte
Data_Valid  output  1  one-cycle pulse, P_DATA updated
Par_Err  output  1  parity mismatch on most recent frame
Stp_Err  output  1  stop bit sampled low on most recent frame

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous, active-low (RST).
- Reset values: P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0. FSM in IDLE. Counters cleared. Synchronizer flops set to 1.
- RX_IN passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- edge_cnt counts 0..Prescale-1 within each bit window. bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: rx_s is captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The sampled bit is the 2-of-3 majority, valid from edge_cnt = Prescale/2+2 onward.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: stays while rx_s=1. On rx_s=0, go to START and set edge_cnt=1, so the detection cycle counts as edge 0.
  - START: at edge_cnt=Prescale-1, if the sampled bit is 0, go to DATA. If it is 1 (glitch), go to IDLE with no output change and no error flags.
  - DATA: at each edge_cnt=Prescale-1, shift the sampled bit into bit position bit_cnt (LSB first). After bit DATA_WIDTH-1, go to PARITY if PAR_EN=1, else go to STOP.
  - PARITY: expected bit = XOR of the data bits XOR PAR_TYP. At edge_cnt=Prescale-1, Par_Err is registered as (sampled != expected). Go to STOP.
  - STOP: at edge_cnt=Prescale-1, Stp_Err is registered as (sampled == 0). Go to IDLE.
- Frame completion, on the cycle after STOP edge Prescale-1:
  - If no parity error and no stop error: P_DATA <= shift register and Data_Valid=1 for exactly one cycle.
  - Otherwise P_DATA holds its previous value and Data_Valid stays 0.
- Par_Err and Stp_Err hold their values until the START->DATA transition of the next frame, where both clear to 0.
- When PAR_EN=0, Par_Err is never set.
- Back-to-back frames: a start bit immediately following the stop window is detected in IDLE on the first rx_s=0 cycle. No idle gap is required.
- Line held low (break): the frame gives Stp_Err=1 with no Data_Valid. The FSM re-enters START the cycle after returning to IDLE and repeats until the line goes high. It must never hang.
- PAR_EN, PAR_TYP and Prescale are sampled continuously. Changing them mid-frame is unsupported but must not lock the FSM.
- An illegal Prescale (<8 or not a power of 2) is unsupported. edge_cnt still wraps at Prescale-1.
- Reset asserted mid-frame: immediate return to reset values. No Data_Valid is emitted for the partial frame.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding
  - the default DATA_WIDTH and PRESCALE_W constants
  - the parity-type constants PAR_EVEN=0 and PAR_ODD=1
- Sub-module uart_rx_sampler holds edge_cnt, the three sample flops and the majority vote. It outputs sampled_bit and bit_done (edge_cnt = Prescale-1).
- The FSM, bit_cnt, shift register, parity/stop checks and output registers stay in uart_rx_fsm.

Test Plan:
- Prescale=8, PAR_EN=0, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> one Data_Valid pulse with P_DATA=0xA5, Par_Err=0, Stp_Err=0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x37 with parity 1 -> P_DATA=0x37 valid. Repeat with parity bit 0 -> Par_Err=1, no Data_Valid, P_DATA stays 0x37.
- Prescale=32, PAR_EN=1, PAR_TYP=1, send 0xFF with parity 1 and stop bit 0 -> Stp_Err=1, Par_Err=0, no Data_Valid. Next good frame 0x00 (parity 1) clears both flags and gives P_DATA=0x00.
- Start glitch: RX_IN low for 3 cycles at Prescale=8 -> FSM returns to IDLE, no outputs change. A valid frame 0x5A immediately after -> P_DATA=0x5A.
- Back-to-back: frames 0x01, 0x80, 0xC3 at Prescale=8 with no idle gap -> three Data_Valid pulses in order with the matching P_DATA. Also single-cycle noise pulses inside data bits (1 of 3 samples flipped) -> data unaffected.
- Assert RST mid-DATA of frame 0x99 -> all outputs 0 immediately. The next full frame 0x42 is received correctly.
